// File: rtl/anim_controller.sv
// Fighter animation state controller: idle/walk/jump/attack/hitstun/lose sequencing on frame_tick.
// Optional macro ATK_BUFFER_EN adds a one-entry attack buffer chaining attacks back to back.
module anim_controller #(
    parameter int TICKS_PER_FRAME = 4,
    parameter int ATK1_FRAMES     = 6,
    parameter int ATK2_FRAMES     = 8,
    parameter int HITSTUN_TICKS   = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       jump_req,
    input  logic       atk1_req,
    input  logic       atk2_req,
    input  logic       on_ground,
    input  logic       hit,
    input  logic       lose,
    output logic [3:0] anim_state,
    output logic [5:0] anim_frame,
    output logic       attack_active,
    output logic       busy
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_WALK = 4'd1,
        ST_JUMP = 4'd2,
        ST_ATK1 = 4'd3,
        ST_ATK2 = 4'd4,
        ST_HIT  = 4'd5,
        ST_LOSE = 4'd6
    } state_t;

    localparam logic [3:0] DIV_LAST  = 4'(TICKS_PER_FRAME - 1);
    localparam logic [5:0] ATK1_LAST = 6'(ATK1_FRAMES - 1);
    localparam logic [5:0] ATK2_LAST = 6'(ATK2_FRAMES - 1);
    localparam logic [7:0] HS_INIT   = 8'(HITSTUN_TICKS);

    state_t     state_q, state_d;
    logic [5:0] frame_q, frame_d;
    logic [3:0] div_q, div_d;
    logic [7:0] hs_q, hs_d;
    logic       attack_active_q, attack_active_d;
    logic       busy_q, busy_d;
    logic [5:0] last_frame;

`ifdef ATK_BUFFER_EN
    // 0 empty, 1 atk1 pending, 2 atk2 pending
    logic [1:0] buf_q, buf_d, buf_eff;
`endif

    assign last_frame = (state_q == ST_ATK2) ? ATK2_LAST : ATK1_LAST;

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        div_d   = div_q;
        hs_d    = hs_q;
`ifdef ATK_BUFFER_EN
        buf_d   = buf_q;
        buf_eff = buf_q;
        if (buf_q == 2'd0)
            buf_eff = atk1_req ? 2'd1 : (atk2_req ? 2'd2 : 2'd0);
`endif
        if (lose) begin
            state_d = ST_LOSE;
            frame_d = '0;
            div_d   = '0;
            hs_d    = '0;
`ifdef ATK_BUFFER_EN
            buf_d   = '0;
`endif
        end else if (state_q == ST_LOSE) begin
            state_d = ST_LOSE;
        end else if (hit) begin
            state_d = ST_HIT;
            frame_d = '0;
            div_d   = '0;
            hs_d    = HS_INIT;
`ifdef ATK_BUFFER_EN
            buf_d   = '0;
`endif
        end else if (frame_tick) begin
            case (state_q)
                ST_IDLE, ST_WALK, ST_JUMP: begin
                    frame_d = '0;
                    div_d   = '0;
                    if (atk1_req)
                        state_d = ST_ATK1;
                    else if (atk2_req)
                        state_d = ST_ATK2;
                    else if (state_q == ST_JUMP)
                        state_d = on_ground ? ST_IDLE : ST_JUMP;
                    else if (jump_req && on_ground)
                        state_d = ST_JUMP;
                    else if (move_left ^ move_right)
                        state_d = ST_WALK;
                    else
                        state_d = ST_IDLE;
                end
                ST_ATK1, ST_ATK2: begin
`ifdef ATK_BUFFER_EN
                    buf_d = buf_eff;
`endif
                    if (div_q == DIV_LAST) begin
                        div_d = '0;
                        if (frame_q == last_frame) begin
                            frame_d = '0;
`ifdef ATK_BUFFER_EN
                            buf_d = '0;
                            case (buf_eff)
                                2'd1:    state_d = ST_ATK1;
                                2'd2:    state_d = ST_ATK2;
                                default: state_d = ST_IDLE;
                            endcase
`else
                            state_d = ST_IDLE;
`endif
                        end else begin
                            frame_d = frame_q + 6'd1;
                        end
                    end else begin
                        div_d = div_q + 4'd1;
                    end
                end
                ST_HIT: begin
                    if (hs_q <= 8'd1) begin
                        state_d = ST_IDLE;
                        hs_d    = '0;
                    end else begin
                        hs_d = hs_q - 8'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        attack_active_d = (state_d == ST_ATK1) || (state_d == ST_ATK2);
        busy_d          = (state_d == ST_ATK1) || (state_d == ST_ATK2) ||
                          (state_d == ST_HIT)  || (state_d == ST_LOSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            frame_q         <= '0;
            div_q           <= '0;
            hs_q            <= '0;
            attack_active_q <= 1'b0;
            busy_q          <= 1'b0;
`ifdef ATK_BUFFER_EN
            buf_q           <= '0;
`endif
        end else begin
            state_q         <= state_d;
            frame_q         <= frame_d;
            div_q           <= div_d;
            hs_q            <= hs_d;
            attack_active_q <= attack_active_d;
            busy_q          <= busy_d;
`ifdef ATK_BUFFER_EN
            buf_q           <= buf_d;
`endif
        end
    end

    assign anim_state    = state_q;
    assign anim_frame    = frame_q;
    assign attack_active = attack_active_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_anim_controller.sv
// Scoreboard bench for anim_controller: expectations queued per frame tick, popped after the edge.
module tb_anim_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       move_left = 1'b0, move_right = 1'b0, jump_req = 1'b0;
    logic       atk1_req = 1'b0, atk2_req = 1'b0, on_ground = 1'b1;
    logic       hit = 1'b0, lose = 1'b0;
    logic [3:0] anim_state;
    logic [5:0] anim_frame;
    logic       attack_active, busy;

    always #5 clk = ~clk;

    anim_controller dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .move_left(move_left), .move_right(move_right), .jump_req(jump_req),
        .atk1_req(atk1_req), .atk2_req(atk2_req), .on_ground(on_ground),
        .hit(hit), .lose(lose),
        .anim_state(anim_state), .anim_frame(anim_frame),
        .attack_active(attack_active), .busy(busy)
    );

    typedef struct packed {
        logic [3:0] st;
        logic [5:0] fr;
        logic       atk;
        logic       bsy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input int st, input int fr);
        exp_t e;
        e.st  = 4'(st);
        e.fr  = 6'(fr);
        e.atk = (st == 3) || (st == 4);
        e.bsy = (st >= 3) && (st <= 6);
        return e;
    endfunction

    // nine quiet cycles then one frame_tick cycle; returns at the negedge after the tick edge
    task automatic run_tick(input logic h = 1'b0, input logic l = 1'b0);
        repeat (9) @(negedge clk);
        frame_tick = 1'b1; hit = h; lose = l;
        @(negedge clk);
        frame_tick = 1'b0; hit = 1'b0; lose = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        sb.push_back(mk(0, 0));
        e = sb.pop_front(); checks++;
        if ({anim_state, anim_frame, attack_active, busy} !== e) begin
            errors++;
            $display("FAIL reset: got st=%0d fr=%0d atk=%0b busy=%0b want st=%0d fr=%0d atk=%0b busy=%0b",
                     anim_state, anim_frame, attack_active, busy, e.st, e.fr, e.atk, e.bsy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_atk1_sequence();
        exp_t e;
        atk1_req = 1'b1;
        for (int k = 0; k <= 24; k++) begin
            sb.push_back(k == 0 ? mk(3, 0) : (k < 24 ? mk(3, k / 4) : mk(0, 0)));
            run_tick();
            atk1_req = 1'b0;
            e = sb.pop_front(); checks++;
            if ({anim_state, anim_frame, attack_active, busy} !== e) begin
                errors++;
                $display("FAIL atk1 tick %0d: got st=%0d fr=%0d atk=%0b busy=%0b want st=%0d fr=%0d atk=%0b busy=%0b",
                         k, anim_state, anim_frame, attack_active, busy, e.st, e.fr, e.atk, e.bsy);
            end
        end
    endtask

    task automatic test_priority();
        exp_t e;
        atk1_req = 1'b1; atk2_req = 1'b1; jump_req = 1'b1; on_ground = 1'b1;
        sb.push_back(mk(3, 0));
        run_tick();
        atk1_req = 1'b0; atk2_req = 1'b0; jump_req = 1'b0;
        e = sb.pop_front(); checks++;
        if ({anim_state, anim_frame, attack_active, busy} !== e) begin
            errors++;
            $display("FAIL priority: got st=%0d fr=%0d atk=%0b busy=%0b want st=%0d fr=%0d atk=%0b busy=%0b",
                     anim_state, anim_frame, attack_active, busy, e.st, e.fr, e.atk, e.bsy);
        end
        // asynchronous reset mid-attack, then the next tick evaluates from idle
        #2 rst_n = 1'b0;
        #1 sb.push_back(mk(0, 0));
        e = sb.pop_front(); checks++;
        if ({anim_state, anim_frame, attack_active, busy} !== e) begin
            errors++;
            $display("FAIL reset mid-attack: got st=%0d fr=%0d atk=%0b busy=%0b want st=%0d fr=%0d",
                     anim_state, anim_frame, attack_active, busy, e.st, e.fr);
        end
        @(negedge clk) rst_n = 1'b1;
        move_right = 1'b1;
        sb.push_back(mk(1, 0));
        run_tick();
        move_right = 1'b0;
        e = sb.pop_front(); checks++;
        if ({anim_state, anim_frame, attack_active, busy} !== e) begin
            errors++;
            $display("FAIL post-reset walk: got st=%0d fr=%0d atk=%0b busy=%0b want st=%0d fr=%0d",
                     anim_state, anim_frame, attack_active, busy, e.st, e.fr);
        end
    endtask

    task automatic test_move();
        exp_t e;
        for (int k = 0; k < 9; k++) begin
            move_left  = (k == 0);
            move_right = (k <= 1);
            jump_req   = (k == 2);
            on_ground  = !(k >= 3 && k <= 7);
            case (k)
                0:       sb.push_back(mk(0, 0));
                1:       sb.push_back(mk(1, 0));
                8:       sb.push_back(mk(0, 0));
                default: sb.push_back(mk(2, 0));
            endcase
            run_tick();
            e = sb.pop_front(); checks++;
            if ({anim_state, anim_frame, attack_active, busy} !== e) begin
                errors++;
                $display("FAIL move step %0d: got st=%0d fr=%0d atk=%0b busy=%0b want st=%0d fr=%0d",
                         k, anim_state, anim_frame, attack_active, busy, e.st, e.fr);
            end
        end
        move_left = 1'b0; move_right = 1'b0; jump_req = 1'b0; on_ground = 1'b1;
    endtask

    task automatic test_hit();
        exp_t e;
        atk2_req = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            sb.push_back(mk(4, k / 4));
            run_tick();
            atk2_req = 1'b0;
            e = sb.pop_front(); checks++;
            if ({anim_state, anim_frame, attack_active, busy} !== e) begin
                errors++;
                $display("FAIL atk2 tick %0d: got st=%0d fr=%0d want st=%0d fr=%0d",
                         k, anim_state, anim_frame, e.st, e.fr);
            end
        end
        for (int h = 0; h < 2; h++) begin
            hit = 1'b1;
            sb.push_back(mk(5, 0));
            @(negedge clk);
            hit = 1'b0;
            e = sb.pop_front(); checks++;
            if ({anim_state, anim_frame, attack_active, busy} !== e) begin
                errors++;
                $display("FAIL hit %0d entry: got st=%0d fr=%0d atk=%0b busy=%0b want st=%0d fr=%0d",
                         h, anim_state, anim_frame, attack_active, busy, e.st, e.fr);
            end
            for (int k = 1; k <= (h == 0 ? 10 : 20); k++) begin
                sb.push_back((h == 1 && k == 20) ? mk(0, 0) : mk(5, 0));
                run_tick();
                e = sb.pop_front(); checks++;
                if ({anim_state, anim_frame, attack_active, busy} !== e) begin
                    errors++;
                    $display("FAIL hitstun %0d tick %0d: got st=%0d busy=%0b want st=%0d busy=%0b",
                             h, k, anim_state, busy, e.st, e.bsy);
                end
            end
        end
    endtask

    task automatic test_buffer();
        exp_t e;
        atk1_req = 1'b1;
        for (int k = 0; k <= 24; k++) begin
            atk2_req = (k == 9);
            if (k < 24)
                sb.push_back(mk(3, k / 4));
            else
`ifdef ATK_BUFFER_EN
                sb.push_back(mk(4, 0));
`else
                sb.push_back(mk(0, 0));
`endif
            run_tick();
            atk1_req = 1'b0;
            e = sb.pop_front(); checks++;
            if ({anim_state, anim_frame, attack_active, busy} !== e) begin
                errors++;
                $display("FAIL buffer tick %0d: got st=%0d fr=%0d atk=%0b want st=%0d fr=%0d atk=%0b",
                         k, anim_state, anim_frame, attack_active, e.st, e.fr, e.atk);
            end
        end
        atk2_req = 1'b0;
    endtask

    task automatic test_lose();
        exp_t e;
        sb.push_back(mk(6, 0));
        run_tick(1'b1, 1'b1);
        e = sb.pop_front(); checks++;
        if ({anim_state, anim_frame, attack_active, busy} !== e) begin
            errors++;
            $display("FAIL lose+hit: got st=%0d fr=%0d atk=%0b busy=%0b want st=%0d busy=%0b",
                     anim_state, anim_frame, attack_active, busy, e.st, e.bsy);
        end
        atk1_req = 1'b1; atk2_req = 1'b1; jump_req = 1'b1; move_right = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(mk(6, 0));
            run_tick(1'b1, 1'b0);
            e = sb.pop_front(); checks++;
            if ({anim_state, anim_frame, attack_active, busy} !== e) begin
                errors++;
                $display("FAIL lose terminal %0d: got st=%0d busy=%0b want st=%0d busy=%0b",
                         k, anim_state, busy, e.st, e.bsy);
            end
        end
        atk1_req = 1'b0; atk2_req = 1'b0; jump_req = 1'b0; move_right = 1'b0;
        #2 rst_n = 1'b0;
        #1 sb.push_back(mk(0, 0));
        e = sb.pop_front(); checks++;
        if ({anim_state, anim_frame, attack_active, busy} !== e) begin
            errors++;
            $display("FAIL lose async reset: got st=%0d busy=%0b want st=%0d busy=%0b",
                     anim_state, busy, e.st, e.bsy);
        end
        @(negedge clk) rst_n = 1'b1;
        sb.push_back(mk(0, 0));
        run_tick();
        e = sb.pop_front(); checks++;
        if ({anim_state, anim_frame, attack_active, busy} !== e) begin
            errors++;
            $display("FAIL after lose reset: got st=%0d busy=%0b want st=%0d busy=%0b",
                     anim_state, busy, e.st, e.bsy);
        end
    endtask

    initial begin
        test_reset();
        test_atk1_sequence();
        test_priority();
        test_move();
        test_hit();
        test_buffer();
        test_lose();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/anim_controller.md
ANIM_CONTROLLER -- requirements
Module: anim_controller

Interface
REQ-001 Parameter TICKS_PER_FRAME, default 4, number of frame_tick pulses per attack animation frame (legal 1..15).
REQ-002 Parameter ATK1_FRAMES, default 6, attack-1 frame count (legal 1..63).
REQ-003 Parameter ATK2_FRAMES, default 8, attack-2 frame count (legal 1..63).
REQ-004 Parameter HITSTUN_TICKS, default 20, hitstun duration in frame_tick pulses (legal 1..255).
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 frame_tick  input  1  single-cycle pulse marking a game-frame boundary.
REQ-008 move_left, move_right  input  1 each  level walk requests.
REQ-009 jump_req  input  1  level jump request.
REQ-010 atk1_req, atk2_req  input  1 each  level attack requests.
REQ-011 on_ground  input  1  level, fighter standing on floor.
REQ-012 hit  input  1  single-cycle pulse, fighter struck.
REQ-013 lose  input  1  level, fighter health exhausted.
REQ-014 anim_state  output  4  encoding 0 idle, 1 walk, 2 jump, 3 atk1, 4 atk2, 5 hit, 6 lose.
REQ-015 anim_frame  output  6  frame index within attack animation, 0 in all other states.
REQ-016 attack_active  output  1  high exactly when anim_state is 3 or 4.
REQ-017 busy  output  1  high when anim_state is 3, 4, 5 or 6 (movement inputs ignored).

Function
REQ-018 All outputs SHALL be registered; a decision made at clock edge N is visible after edge N.
REQ-019 lose high on any cycle SHALL force state 6 at the next edge, overriding everything; state 6 is terminal until reset.
REQ-020 hit pulse in any state except 6 SHALL force state 5 at the next edge, loading hitstun counter with HITSTUN_TICKS; hit during state 5 SHALL reload the counter.
REQ-021 State 5 SHALL decrement the counter on each frame_tick and go to state 0 on the frame_tick where the counter reaches 0.
REQ-022 All other transitions SHALL be evaluated only on frame_tick cycles, priority atk1_req > atk2_req > jump_req > walk > idle.
REQ-023 From states 0/1: atk1_req -> 3, atk2_req -> 4, jump_req with on_ground -> 2, exactly one of move_left/move_right -> 1, otherwise -> 0 (both move inputs high -> 0).
REQ-024 Attack entry SHALL set anim_frame 0 and tick divider 0; divider increments per frame_tick, at TICKS_PER_FRAME-1 it wraps to 0 and anim_frame increments.
REQ-025 When anim_frame equals last frame (ATKn_FRAMES-1) and divider wraps, attack SHALL end: next state 0 (or buffered attack per REQ-031); attacks not interruptible except by hit/lose.
REQ-026 State 2 SHALL persist at least one frame_tick; on a later frame_tick with on_ground high, go to 0; attacks from jump permitted (jump -> 3/4 on request).
REQ-027 hit and lose arriving on a frame_tick cycle SHALL take priority over that cycle's tick-driven transition; lose beats hit.

Reset
REQ-028 rst_n low SHALL asynchronously clear anim_state to 0, anim_frame to 0, attack_active 0, busy 0, all counters and buffer 0.
REQ-029 Reset mid-attack or mid-hitstun SHALL abandon the sequence; first frame_tick after release evaluates from state 0.
REQ-030 Reset release SHALL be synchronous-safe: no transition on the release edge itself.

Configuration
REQ-031 With ATK_BUFFER_EN defined: an atk1_req/atk2_req sampled on a frame_tick during state 3/4 SHALL be latched in a one-entry buffer (atk1 wins, first latch kept); on attack end the buffered attack starts immediately at frame 0 and the buffer clears; hit/lose clear the buffer.
REQ-032 Without ATK_BUFFER_EN: no buffer logic; requests during an attack are ignored and attack end always goes to state 0.

Verification
REQ-033 Reset, frame_tick every 10 cycles, atk1_req held one tick -> state 3, anim_frame 0..5 each held 4 ticks, state 0 after 24 ticks, attack_active high throughout.
REQ-034 atk1_req and atk2_req and jump_req together on a tick from idle -> state 3.
REQ-035 hit pulse at anim_frame 3 of atk2 -> state 5 next edge, anim_frame 0; second hit after 10 ticks -> state 0 exactly 20 ticks after second hit.
REQ-036 lose with simultaneous hit on a frame_tick -> state 6, stays 6 with all further inputs; rst_n low -> state 0 asynchronously.
REQ-037 move_left and move_right both high -> state 0; only move_right -> 1; jump_req with on_ground -> 2, on_ground low 5 ticks then high -> 0.
REQ-038 ATK_BUFFER_EN defined: atk2_req at atk1 frame 2 -> state 4 frame 0 on tick ending atk1; undefined -> state 0.
